// File: rtl/relax_osc_freq_meter.sv
// relax_osc_freq_meter
//   Counts rising edges of a relaxation-oscillator comparator output over a
//   programmable gate of N = 2^(gate_sel_i+8) clk cycles.
//
//   Optional feature macro: RELAX_METER_CONT_EN
//     When defined, cont_i=1 in DONE starts the next gate immediately
//     (continuous mode). When undefined, cont_i is ignored.
//
// Ports
//   clk        : block clock
//   rst_n      : asynchronous active-low reset
//   osc_i      : comparator output, asynchronous to clk
//   start_i    : starts a measurement when sampled high in IDLE
//   gate_sel_i : gate length select, captured at start
//   cont_i     : continuous-mode request (RELAX_METER_CONT_EN only)
//   result_o   : saturating edge count of the last completed measurement
//   valid_o    : one-cycle pulse when result_o/ovf_o update
//   busy_o     : high while in GATE or DONE
//   ovf_o      : edge count saturated in the last completed measurement
//
// Handshake: start_i is a request sampled only in IDLE (no ready signal;
// requests while busy_o=1 are dropped). valid_o is a single-cycle strobe
// with no back-pressure; result_o/ovf_o hold until the next strobe.
//
// SYNC_STAGES must be 2 or 3.

module relax_osc_freq_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             osc_i,
    input  logic             start_i,
    input  logic [2:0]       gate_sel_i,
    input  logic             cont_i,
    output logic [CNT_W-1:0] result_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             ovf_o
);

    localparam int GATE_W = 16;  // holds 2^15 = 32768

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   load_gate;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   osc_rise;
    logic [1:0]             rst_sync_q;
    logic                   run_en;
    logic [GATE_W-1:0]      gate_cnt_q;
    logic [CNT_W-1:0]       edge_cnt_q;
    logic                   ovf_flag_q;

    // Reset release is retimed to clk: start_i is only accepted once both
    // flops have filled with ones, i.e. never on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign run_en = rst_sync_q[1];

    // Synchronizer chain plus previous-value flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end
    assign osc_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; load_gate marks the cycle that (re)arms a gate.
    always_comb begin
        state_d   = state_q;
        load_gate = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && run_en) begin
                    state_d   = GATE;
                    load_gate = 1'b1;
                end
            end
            GATE: begin
                if (gate_cnt_q == GATE_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
`ifdef RELAX_METER_CONT_EN
                if (cont_i) begin
                    state_d   = GATE;
                    load_gate = 1'b1;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

`ifndef RELAX_METER_CONT_EN
    logic unused_cont;
    assign unused_cont = cont_i;
`endif

    // Gate counter, saturating edge counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_flag_q <= 1'b0;
            result_o   <= '0;
            ovf_o      <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (load_gate) begin
                // gate_sel_i is consumed only here, so later changes are inert
                gate_cnt_q <= GATE_W'(1) << ({1'b0, gate_sel_i} + 4'd8);
                edge_cnt_q <= '0;
                ovf_flag_q <= 1'b0;
            end else if (state_q == GATE) begin
                gate_cnt_q <= gate_cnt_q - GATE_W'(1);
                if (osc_rise) begin
                    if (edge_cnt_q == {CNT_W{1'b1}}) begin
                        ovf_flag_q <= 1'b1;
                    end else begin
                        edge_cnt_q <= edge_cnt_q + CNT_W'(1);
                    end
                end
            end
            // DONE publishes the count; in continuous mode this coincides
            // with load_gate, and the non-blocking copy sees the old count.
            if (state_q == DONE) begin
                result_o <= edge_cnt_q;
                ovf_o    <= ovf_flag_q;
                valid_o  <= 1'b1;
            end
        end
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_relax_osc_freq_meter.sv
module tb_relax_osc_freq_meter;

    logic        clk;
    logic        rst_n;
    logic        osc_i;
    logic        start_i;
    logic [2:0]  gate_sel_i;
    logic        cont_i;
    logic [15:0] result_o;
    logic        valid_o;
    logic        busy_o;
    logic        ovf_o;
    logic [7:0]  result8;
    logic        valid8;
    logic        busy8;
    logic        ovf8;

    int total = 0;
    int bad   = 0;

    // ---------------- DUTs ----------------
    relax_osc_freq_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .osc_i(osc_i), .start_i(start_i),
        .gate_sel_i(gate_sel_i), .cont_i(cont_i), .result_o(result_o),
        .valid_o(valid_o), .busy_o(busy_o), .ovf_o(ovf_o)
    );

    relax_osc_freq_meter #(.CNT_W(8), .SYNC_STAGES(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .osc_i(osc_i), .start_i(start_i),
        .gate_sel_i(gate_sel_i), .cont_i(cont_i), .result_o(result8),
        .valid_o(valid8), .busy_o(busy8), .ovf_o(ovf8)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- oscillator driver ----------------
    // osc_hist[k] is the osc_i value sampled at posedge number k.
    int cyc = 0;
    int osc_mode = 0;  // 0 static low, 1 period 8, 2 toggle every clk, 3 random
    bit osc_hist [0:99999];

    initial begin
        osc_i = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            case (osc_mode)
                0:       osc_i = 1'b0;
                1:       osc_i = ((cyc % 8) < 4);
                2:       osc_i = ~osc_i;
                default: osc_i = 1'($urandom_range(0, 1));
            endcase
            if (cyc + 1 <= 99999) osc_hist[cyc+1] = osc_i;
        end
    end

    // ---------------- checker ----------------
    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A measurement whose start was sampled at edge s counts every rising
    // transition of osc_i that reaches the edge detector during the N gate
    // cycles; with st synchronizer stages that is transitions sampled at
    // edges s+1-st .. s+n-st.
    function automatic int raw_rises(input int s, input int n, input int st);
        int r = 0;
        for (int k = s + 1 - st; k <= s + n - st; k++) begin
            if (osc_hist[k] && !osc_hist[k-1]) r++;
        end
        return r;
    endfunction

    function automatic longint sat(input int r, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (r > mx) ? mx : longint'(r);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_meas(input int sel, input int mode, input bit mid_start,
                           input bit cont_val, input string tag);
        int  n, s, c, lat, busy_cnt, waited, r16, r8, extra_v;
        bit  seen;
        n = 1 << (sel + 8);
        osc_mode = mode;
        @(posedge clk); #1;
        gate_sel_i = 3'(sel);
        cont_i     = cont_val;
        start_i    = 1'b1;
        c = cyc;
        s = c + 1;
        @(posedge clk); #1;
        start_i    = 1'b0;
        gate_sel_i = 3'($urandom_range(0, 7));
        seen = 0; busy_cnt = 0; waited = 0; lat = 0;
        while (!seen && waited < n + 20) begin
            @(negedge clk);
            waited++;
            if (busy_o) busy_cnt++;
            if (valid_o) begin
                seen = 1;
                lat  = cyc - c;
            end
            if (mid_start && cyc == s + 50) begin
                start_i = 1'b1; gate_sel_i = 3'd7;
            end else if (mid_start && cyc == s + 51) begin
                start_i = 1'b0;
            end
        end
        chk({tag, "_valid_seen"}, longint'(seen), 1);
        chk({tag, "_latency"}, longint'(lat), longint'(n + 2));
        chk({tag, "_busy_len"}, longint'(busy_cnt), longint'(n + 1));
        r16 = raw_rises(s, n, 2);
        r8  = raw_rises(s, n, 3);
        chk({tag, "_result16"}, longint'(result_o), sat(r16, 16));
        chk({tag, "_ovf16"}, longint'(ovf_o), longint'(r16 > 65535));
        chk({tag, "_result8"}, longint'(result8), sat(r8, 8));
        chk({tag, "_ovf8"}, longint'(ovf8), longint'(r8 > 255));
        chk({tag, "_valid8_sync"}, longint'(valid8), longint'(valid_o));
        @(negedge clk);
        chk({tag, "_valid_width"}, longint'(valid_o), 0);
        chk({tag, "_idle_after"}, longint'(busy_o), 0);
        cont_i = 1'b0;
        if (mid_start) begin
            extra_v = 0;
            repeat (40) begin
                @(negedge clk);
                if (valid_o || busy_o) extra_v++;
            end
            chk({tag, "_no_restart"}, longint'(extra_v), 0);
        end
    endtask

    task automatic do_reset_mid_gate();
        int s, vcnt;
        osc_mode = 1;
        @(posedge clk); #1;
        gate_sel_i = 3'd0; start_i = 1'b1;
        s = cyc + 1;
        @(posedge clk); #1;
        start_i = 1'b0;
        while (cyc < s + 100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", longint'(busy_o), 0);
        chk("rstmid_valid", longint'(valid_o), 0);
        chk("rstmid_result", longint'(result_o), 0);
        chk("rstmid_result8", longint'(result8), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        vcnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (valid_o || busy_o) vcnt++;
        end
        chk("rstmid_no_valid", longint'(vcnt), 0);
        chk("rstmid_result_after", longint'(result_o), 0);
    endtask

`ifdef RELAX_METER_CONT_EN
    task automatic do_cont();
        int n, s, vi, waited, drops, last_v;
        n = 256;
        osc_mode = 1;
        @(posedge clk); #1;
        gate_sel_i = 3'd0; cont_i = 1'b1; start_i = 1'b1;
        s = cyc + 1;
        @(posedge clk); #1;
        start_i = 1'b0;
        vi = 0; waited = 0; drops = 0; last_v = 0;
        while (vi < 3 && waited < 3 * (n + 1) + 20) begin
            @(negedge clk);
            waited++;
            if (!busy_o) drops++;
            if (valid_o) begin
                if (vi > 0) chk("cont_interval", longint'(cyc - last_v), longint'(n + 1));
                chk("cont_result", longint'(result_o),
                    sat(raw_rises(s + vi * (n + 1), n, 2), 16));
                last_v = cyc;
                vi++;
            end
        end
        chk("cont_pulses", longint'(vi), 3);
        chk("cont_busy_drops", longint'(drops), 0);
        cont_i = 1'b0;
        repeat (n + 10) @(negedge clk);
        chk("cont_stop_idle", longint'(busy_o), 0);
    endtask
`endif

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; start_i = 1'b0; gate_sel_i = 3'd0; cont_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_result", longint'(result_o), 0);
        chk("rst_valid", longint'(valid_o), 0);
        chk("rst_busy", longint'(busy_o), 0);
        chk("rst_ovf", longint'(ovf_o), 0);
        chk("rst_result8", longint'(result8), 0);

        // start held high across release must not be taken on the first edge
        rst_n = 1'b1; start_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_no_early_start", longint'(busy_o), 0);
        start_i = 1'b0;
        repeat (4) @(negedge clk);

        do_meas(0, 1, 1'b0, 1'b0, "freq_p8");
        do_meas(1, 2, 1'b0, 1'b0, "sat_toggle");
        do_meas(1, 0, 1'b0, 1'b0, "sat_static");
        do_meas(0, 1, 1'b1, 1'b0, "ign_start");
        do_reset_mid_gate();
        do_meas(0, 1, 1'b0, 1'b0, "post_rst");
        for (int i = 0; i < 8; i++) begin
`ifdef RELAX_METER_CONT_EN
            do_meas($urandom_range(0, 2), $urandom_range(0, 3), 1'b0, 1'b0, "rand");
`else
            do_meas($urandom_range(0, 2), $urandom_range(0, 3), 1'b0,
                    1'($urandom_range(0, 1)), "rand");
`endif
        end
`ifdef RELAX_METER_CONT_EN
        do_cont();
`endif
        do_meas(7, 2, 1'b0, 1'b0, "max_rate");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/relax_osc_freq_meter.md
RELAX_OSC_FREQ_METER -- requirements
Module: relax_osc_freq_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the edge counter and of result_o.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on osc_i; legal values are 2 and 3.
REQ-003 SHALL have port clk, input, width 1: single clock for the block.
REQ-004 SHALL have port rst_n, input, width 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port osc_i, input, width 1: relaxation-oscillator comparator output, asynchronous to clk.
REQ-006 SHALL have port start_i, input, width 1: begins a measurement when sampled high in IDLE.
REQ-007 SHALL have port gate_sel_i, input, width 3: selects the gate length.
REQ-008 SHALL have port cont_i, input, width 1: continuous-mode request; it is used only under RELAX_METER_CONT_EN.
REQ-009 SHALL have port result_o, output, width CNT_W: count from the last completed measurement.
REQ-010 SHALL have port valid_o, output, width 1: one-cycle pulse when result_o updates.
REQ-011 SHALL have port busy_o, output, width 1: high while the state machine is in GATE or DONE.
REQ-012 SHALL have port ovf_o, output, width 1: the count saturated in the last completed measurement.

Function
REQ-013 SHALL pass osc_i through SYNC_STAGES flops, then a rising-edge detector (current sync bit high, previous sync bit low).
REQ-014 SHALL implement the states IDLE, GATE and DONE.
REQ-015 IDLE: on start_i=1, SHALL capture gate_sel_i, load the gate counter with N = 2^(gate_sel+8) clk cycles (range 256..32768), clear the edge counter and the internal ovf flag, and enter GATE in the next cycle.
REQ-016 GATE SHALL last exactly N cycles.
REQ-017 Each detected edge in a GATE cycle SHALL increment the edge counter.
REQ-018 Detected edges outside GATE SHALL be ignored.
REQ-019 The edge counter SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-020 An increment attempted while the counter is at its maximum SHALL set the internal ovf flag.
REQ-021 DONE SHALL last one cycle: it copies the edge counter to result_o and the ovf flag to ovf_o, and pulses valid_o=1.
REQ-022 On leaving DONE, the block SHALL return to IDLE, unless continuous mode applies (REQ-031).
REQ-023 start_i SHALL be ignored while busy_o=1.
REQ-024 gate_sel_i changes during GATE SHALL have no effect.
REQ-025 result_o and ovf_o SHALL hold their values until the next DONE.
REQ-026 busy_o SHALL be 1 from the first GATE cycle through the DONE cycle.
REQ-027 Latency from the start_i sample to valid_o SHALL be N+2 cycles.

Reset
REQ-028 On rst_n=0, SHALL enter IDLE immediately and clear: synchronizer flops, edge-detect flop, gate counter, edge counter, result_o=0, valid_o=0, busy_o=0, ovf_o=0.
REQ-029 Reset asserted mid-GATE SHALL abort the measurement with no valid_o pulse, and result_o SHALL read 0 afterwards.
REQ-030 Reset deassertion SHALL be synchronized to clk; the first start_i SHALL be honoured no earlier than the second clk edge after release.

Configuration
REQ-031 With RELAX_METER_CONT_EN defined: if cont_i=1 in DONE, the block SHALL go directly to GATE, re-capture gate_sel_i, and clear the counter and ovf, with no IDLE cycle. Back-to-back gates are N+1 cycles apart, and busy_o stays 1.
REQ-032 Without RELAX_METER_CONT_EN: cont_i SHALL be ignored, DONE SHALL always go to IDLE, and no continuous-mode logic SHALL be synthesized.

Verification
REQ-033 Frequency: osc_i period 8 clk (4 high / 4 low), gate_sel=0, pulse start -> valid_o after 258 cycles, result_o in {31,32}, ovf_o=0.
REQ-034 Max rate: osc_i toggling every clk, gate_sel=7 -> result_o in {16383,16384}, valid_o one cycle wide, busy_o high for exactly 32769 cycles.
REQ-035 Saturation: CNT_W=8, osc_i toggling every clk, gate_sel=1 (512 cycles) -> result_o=255, ovf_o=1; the next measurement with osc_i static -> result_o=0, ovf_o=0.
REQ-036 Reset mid-gate: rst_n low 3 cycles at gate cycle 100 -> busy_o=0 immediately, no valid_o, result_o=0; a subsequent start gives a normal result.
REQ-037 Ignored start: start_i pulsed at gate cycle 50 and gate_sel changed to 7 -> single valid_o at cycle 258, gate length 256.
REQ-038 Continuous (macro defined): cont_i=1, osc period 8, gate_sel=0 -> valid_o pulses every 257 cycles, each result_o in {31,32}, busy_o never drops.
